burst_arbiter_memory: RTL and testbench

Parametrised multi-requester main-memory model with burst transfers and round-robin arbitration. It replaces the fixed single-port memory behind the OTTER caches: up to NUM_PORTS requesters (for example the I-cache and D-cache controllers) share one storage array. Each transaction moves one cache line of BURST_LEN words after a programmable access delay. Bursts start at the requested word and wrap within the line (critical-word-first).

---
 rtl/burst_arbiter_memory_if.sv | 36 +++
 rtl/burst_arbiter_memory.sv | 161 ++++++++++++++++
 tb/tb_burst_arbiter_memory.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_arbiter_memory_if.sv
// Requester <-> memory bus for burst_arbiter_memory: per-port request/address/write-data
// inputs and shared grant/beat outputs.
interface burst_arbiter_memory_if #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 4
);
  localparam int BW = $clog2(BURST_LEN);

  // Handshake: a port holds REQ (level) with WE/ADDR stable until its GNT bit rises; the
  // memory latches WE/ADDR at that edge and keeps GNT for the whole transaction. Read beats
  // are qualified by MEMVALID; a write beat is consumed at each edge where WREADY is high,
  // so the requester presents beat k data while WREADY is high and advances on that edge.
  // DONE marks the last beat; no beat can be stalled by the requester.
  logic [NUM_PORTS-1:0]            REQ;
  logic [NUM_PORTS-1:0]            WE;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] ADDR;
  logic [NUM_PORTS*DATA_WIDTH-1:0] WDATA;
  logic [NUM_PORTS-1:0]            GNT;
  logic                            MEMVALID;
  logic                            WREADY;
  logic [DATA_WIDTH-1:0]           DATA_OUT;
  logic [BW-1:0]                   BEAT_IDX;
  logic                            DONE;

  modport master (
    output REQ, WE, ADDR, WDATA,
    input  GNT, MEMVALID, WREADY, DATA_OUT, BEAT_IDX, DONE
  );

  modport slave (
    input  REQ, WE, ADDR, WDATA,
    output GNT, MEMVALID, WREADY, DATA_OUT, BEAT_IDX, DONE
  );
endinterface

// File: rtl/burst_arbiter_memory.sv
// Shared main-memory model: round-robin arbitration between requesters, a fixed access
// delay, then one wrapping critical-word-first burst of BURST_LEN words per grant.
module burst_arbiter_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 16384,
  parameter int NUM_PORTS    = 2,
  parameter int DELAY_CYCLES = 10,
  parameter int BURST_LEN    = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  burst_arbiter_memory_if.slave  bus,
  output logic [1:0]             dbg_state
);
  localparam int IW = $clog2(DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(DELAY_CYCLES + BURST_LEN + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_BURST = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [PW-1:0]         port_q, port_d;
  logic                  we_q, we_d;
  logic [IW-BW-1:0]      line_q, line_d;
  logic [BW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic                  memvalid_q, memvalid_d;
  logic                  wready_q, wready_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  found;
  logic [PW-1:0]         win;
  logic [IW-1:0]         grant_index;
  logic [BW-1:0]         idx_next;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] wdata_sel;

  assign idx_next  = idx_q + BW'(1);
  assign mem_we    = (state_q == S_BURST) && wready_q;
  assign wdata_sel = bus.WDATA[int'(port_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    port_d     = port_q;
    we_d       = we_q;
    line_d     = line_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    memvalid_d = 1'b0;
    wready_d   = 1'b0;
    done_d     = 1'b0;
    data_out_d = data_out_q;

    // Scan from the round-robin pointer; the first requesting port wins.
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int p;
      p = (int'(rr_q) + i) % NUM_PORTS;
      if (!found && bus.REQ[p]) begin
        found = 1'b1;
        win   = PW'(p);
      end
    end
    grant_index = IW'(bus.ADDR >> (int'(win) * ADDR_WIDTH));

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_WAIT;
          port_d      = win;
          we_d        = bus.WE[win];
          line_d      = grant_index[IW-1:BW];
          idx_d       = grant_index[BW-1:0];
          cnt_d       = CW'(DELAY_CYCLES - 1);
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          rr_d        = PW'((int'(win) + 1) % NUM_PORTS);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_BURST;
          cnt_d      = CW'(BURST_LEN - 1);
          memvalid_d = !we_q;
          wready_d   = we_q;
          if (!we_q) data_out_d = mem_q[{line_q, idx_q}];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BURST: begin
        // cnt_q counts beats still to come after the current one.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end else begin
          cnt_d      = cnt_q - CW'(1);
          idx_d      = idx_next;
          memvalid_d = !we_q;
          wready_d   = we_q;
          done_d     = (cnt_q == CW'(1));
          if (!we_q) data_out_d = mem_q[{line_q, idx_next}];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      port_q     <= '0;
      we_q       <= 1'b0;
      line_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      memvalid_q <= 1'b0;
      wready_q   <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      port_q     <= port_d;
      we_q       <= we_d;
      line_q     <= line_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      memvalid_q <= memvalid_d;
      wready_q   <= wready_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage deliberately has no reset so contents survive RST_N.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[{line_q, idx_q}] <= wdata_sel;
  end

  assign bus.GNT      = gnt_q;
  assign bus.MEMVALID = memvalid_q;
  assign bus.WREADY   = wready_q;
  assign bus.DATA_OUT = data_out_q;
  assign bus.BEAT_IDX = idx_q;
  assign bus.DONE     = done_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_burst_arbiter_memory.sv
// Directed bench for burst_arbiter_memory: default 2-port instance plus a DELAY=1,
// BURST=2 single-port instance; outputs sampled on the falling edge.
module tb_burst_arbiter_memory;
  localparam int D = 10;
  localparam int B = 4;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_s;

  int checks;
  int errors;
  logic [31:0] exp_q[$];
  logic [31:0] wd_q[$];

  burst_arbiter_memory_if #(.NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(4)) bus ();
  burst_arbiter_memory_if #(.NUM_PORTS(1), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(2)) bus_s ();

  burst_arbiter_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16384),
    .NUM_PORTS(2), .DELAY_CYCLES(D), .BURST_LEN(B)
  ) dut (.CLK(clk), .RST_N(rst_n), .bus(bus), .dbg_state(dbg_state));

  burst_arbiter_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64),
    .NUM_PORTS(1), .DELAY_CYCLES(1), .BURST_LEN(2)
  ) dut_s (.CLK(clk), .RST_N(rst_n), .bus(bus_s), .dbg_state(dbg_state_s));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction on the 2-port DUT, checked every cycle from grant to the bubble.
  task automatic run_txn(input int port, input bit we, input logic [31:0] addr);
    logic [1:0] start;
    logic [1:0] exp_gnt;
    logic [1:0] exp_idx;
    logic [31:0] exp_d;
    int k;
    start = addr[1:0];
    bus.REQ[port] = 1'b1;
    bus.WE[port]  = we;
    bus.ADDR[port*32 +: 32] = addr;
    for (int n = 1; n <= D + B + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.REQ[port] = 1'b0;
        bus.WE[port]  = ~we;
        bus.ADDR[port*32 +: 32] = 32'hDEAD_BEEF;
      end
      exp_gnt = (n <= D + B) ? (2'b01 << port) : 2'b00;
      checks++;
      if (bus.GNT !== exp_gnt) begin
        errors++;
        $display("FAIL gnt n=%0d: got %b expected %b", n, bus.GNT, exp_gnt);
      end
      if (n > D && n <= D + B) begin
        k = n - 1 - D;
        exp_idx = 2'(int'(start) + k);
        checks++;
        if (bus.MEMVALID !== !we || bus.WREADY !== we) begin
          errors++;
          $display("FAIL beat_strobe k=%0d: got valid=%b wready=%b expected valid=%b wready=%b",
                   k, bus.MEMVALID, bus.WREADY, !we, we);
        end
        checks++;
        if (bus.BEAT_IDX !== exp_idx) begin
          errors++;
          $display("FAIL beat_idx k=%0d: got %0d expected %0d", k, bus.BEAT_IDX, exp_idx);
        end
        checks++;
        if (bus.DONE !== (k == B - 1)) begin
          errors++;
          $display("FAIL done k=%0d: got %b expected %b", k, bus.DONE, (k == B - 1));
        end
        if (we) begin
          bus.WDATA[port*32 +: 32] = wd_q.pop_front();
        end else begin
          exp_d = exp_q.pop_front();
          checks++;
          if (bus.DATA_OUT !== exp_d) begin
            errors++;
            $display("FAIL read_data k=%0d: got %h expected %h", k, bus.DATA_OUT, exp_d);
          end
        end
      end else begin
        checks++;
        if (bus.MEMVALID !== 1'b0 || bus.WREADY !== 1'b0 || bus.DONE !== 1'b0) begin
          errors++;
          $display("FAIL idle_strobes n=%0d: got valid=%b wready=%b done=%b expected 0",
                   n, bus.MEMVALID, bus.WREADY, bus.DONE);
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.GNT !== 2'b00 || bus.MEMVALID !== 1'b0 || bus.WREADY !== 1'b0 ||
        bus.DONE !== 1'b0 || bus.DATA_OUT !== 32'h0 || bus.BEAT_IDX !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b v=%b wr=%b done=%b data=%h idx=%0d expected all 0",
               bus.GNT, bus.MEMVALID, bus.WREADY, bus.DONE, bus.DATA_OUT, bus.BEAT_IDX);
    end
    checks++;
    if (bus_s.GNT !== 1'b0 || bus_s.MEMVALID !== 1'b0 || bus_s.DATA_OUT !== 32'h0) begin
      errors++;
      $display("FAIL reset_small: got gnt=%b v=%b data=%h expected 0",
               bus_s.GNT, bus_s.MEMVALID, bus_s.DATA_OUT);
    end
  endtask

  task automatic test_read_line();
    wd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_txn(0, 1'b1, 32'h100);
    wd_q = '{32'hB4, 32'hB5, 32'hB6, 32'hB7};
    run_txn(1, 1'b1, 32'h104);
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_txn(0, 1'b0, 32'h100);
    exp_q = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    run_txn(0, 1'b0, 32'h102);
  endtask

  task automatic test_write_wrap();
    wd_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_txn(1, 1'b1, 32'h203);
    exp_q = '{32'h22, 32'h33, 32'h44, 32'h11};
    run_txn(0, 1'b0, 32'h200);
  endtask

  task automatic test_round_robin();
    logic [31:0] rd0 [4];
    logic [31:0] rd1 [4];
    logic [1:0] exp_gnt;
    int m;
    int tr;
    rd0 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    rd1 = '{32'h22, 32'h33, 32'h44, 32'h11};
    apply_reset();
    bus.WE = 2'b00;
    bus.ADDR = {32'h200, 32'h100};
    bus.REQ = 2'b11;
    for (int n = 1; n <= 61; n++) begin
      @(negedge clk);
      if (n == 59) bus.REQ = 2'b00;
      m  = (n - 1) % 15;
      tr = (n - 1) / 15;
      exp_gnt = (m == 14 || n > 59) ? 2'b00 : (2'b01 << (tr % 2));
      checks++;
      if (bus.GNT !== exp_gnt) begin
        errors++;
        $display("FAIL rr_gnt n=%0d: got %b expected %b", n, bus.GNT, exp_gnt);
      end
      if (n <= 59 && m >= 10 && m <= 13) begin
        checks++;
        if (bus.MEMVALID !== 1'b1 || bus.DONE !== (m == 13) ||
            bus.DATA_OUT !== ((tr % 2 == 0) ? rd0[m-10] : rd1[m-10])) begin
          errors++;
          $display("FAIL rr_beat n=%0d: got v=%b done=%b data=%h expected data %h",
                   n, bus.MEMVALID, bus.DONE, bus.DATA_OUT,
                   (tr % 2 == 0) ? rd0[m-10] : rd1[m-10]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    wd_q = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
    run_txn(0, 1'b1, 32'h300);
    bus.REQ[0] = 1'b1;
    bus.WE[0]  = 1'b1;
    bus.ADDR[31:0] = 32'h300;
    for (int n = 1; n <= D + 3; n++) begin
      @(negedge clk);
      if (n == 1) bus.REQ[0] = 1'b0;
      if (n > D) bus.WDATA[31:0] = 32'(5 + n - D - 1);
    end
    checks++;
    if (bus.WREADY !== 1'b1 || bus.BEAT_IDX !== 2'd2) begin
      errors++;
      $display("FAIL abort_beat2: got wready=%b idx=%0d expected 1 and 2", bus.WREADY, bus.BEAT_IDX);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.GNT !== 2'b00 || bus.MEMVALID !== 1'b0 || bus.WREADY !== 1'b0 ||
        bus.DONE !== 1'b0 || bus.DATA_OUT !== 32'h0 || bus.BEAT_IDX !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b v=%b wr=%b done=%b data=%h idx=%0d expected all 0",
               bus.GNT, bus.MEMVALID, bus.WREADY, bus.DONE, bus.DATA_OUT, bus.BEAT_IDX);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.REQ[1] = 1'b1;
    bus.WE[1]  = 1'b0;
    bus.ADDR[63:32] = 32'h200;
    exp_q = '{32'h5, 32'h6, 32'hF2, 32'hF3};
    run_txn(0, 1'b0, 32'h300);
    bus.REQ[1] = 1'b0;
  endtask

  task automatic small_txn(input bit we, input logic [31:0] addr,
                           input logic [31:0] d0, input logic [31:0] d1);
    logic exp_idx;
    bus_s.REQ = 1'b1;
    bus_s.WE  = we;
    bus_s.ADDR = addr;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) bus_s.REQ = 1'b0;
      checks++;
      if (bus_s.GNT !== (n <= 3)) begin
        errors++;
        $display("FAIL small_gnt n=%0d: got %b expected %b", n, bus_s.GNT, (n <= 3));
      end
      if (n == 2 || n == 3) begin
        exp_idx = addr[0] ^ (n == 3);
        checks++;
        if (bus_s.MEMVALID !== !we || bus_s.WREADY !== we || bus_s.DONE !== (n == 3) ||
            bus_s.BEAT_IDX !== exp_idx) begin
          errors++;
          $display("FAIL small_beat n=%0d: got v=%b wr=%b done=%b idx=%b expected v=%b wr=%b done=%b idx=%b",
                   n, bus_s.MEMVALID, bus_s.WREADY, bus_s.DONE, bus_s.BEAT_IDX,
                   !we, we, (n == 3), exp_idx);
        end
        if (we) begin
          bus_s.WDATA = (n == 2) ? d0 : d1;
        end else begin
          checks++;
          if (bus_s.DATA_OUT !== ((n == 2) ? d0 : d1)) begin
            errors++;
            $display("FAIL small_data n=%0d: got %h expected %h",
                     n, bus_s.DATA_OUT, (n == 2) ? d0 : d1);
          end
        end
      end else begin
        checks++;
        if (bus_s.MEMVALID !== 1'b0 || bus_s.WREADY !== 1'b0 || bus_s.DONE !== 1'b0) begin
          errors++;
          $display("FAIL small_idle n=%0d: got v=%b wr=%b done=%b expected 0",
                   n, bus_s.MEMVALID, bus_s.WREADY, bus_s.DONE);
        end
      end
    end
  endtask

  task automatic test_short_burst();
    small_txn(1'b1, 32'h10, 32'h7, 32'h8);
    small_txn(1'b0, 32'h11, 32'h8, 32'h7);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.REQ = '0;
    bus.WE = '0;
    bus.ADDR = '0;
    bus.WDATA = '0;
    bus_s.REQ = '0;
    bus_s.WE = '0;
    bus_s.ADDR = '0;
    bus_s.WDATA = '0;
    @(negedge clk);
    test_reset();
    test_read_line();
    test_write_wrap();
    test_round_robin();
    test_reset_abort();
    test_short_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
